// File: rtl/spi_pkg.sv
// Shared POCI types and constants: FSM state enum, address type, default address window.
package spi_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [7:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } poci_state_t;

  localparam addr_t POCI_MAX_ADDR   = 8'd59;
  localparam addr_t POCI_FIRST_ADDR = 8'd1;

  // Sequential register read order: step by one, wrap back to the bottom of the window.
  function automatic addr_t poci_next_addr(addr_t cur, addr_t first, addr_t last);
    return (cur == last) ? first : addr_t'(cur + 8'd1);
  endfunction

endpackage

// File: rtl/poci_shifter_if.sv
// POCI shifter bus bundle: control from the SPI front end, register mux, serial output.
interface poci_shifter_if;
  import spi_pkg::*;

  logic              start;
  logic              stop;
  addr_t             start_addr;
  addr_t             rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              serial_out;
  logic              busy;
  logic              byte_done;
  logic              addr_err;

  modport master (
    output start, stop, start_addr, rd_data,
    input  rd_addr, serial_out, busy, byte_done, addr_err
  );

  modport slave (
    input  start, stop, start_addr, rd_data,
    output rd_addr, serial_out, busy, byte_done, addr_err
  );
endinterface

// File: rtl/poci_shifter_addr_ctr.sv
// Read-address register for the POCI shifter: synchronous load, increment with wrap.
module poci_addr_ctr
  import spi_pkg::*;
#(
  parameter addr_t FIRST_ADDR = POCI_FIRST_ADDR,
  parameter addr_t MAX_ADDR   = POCI_MAX_ADDR
) (
  input  logic  sclk,
  input  logic  rstn,
  input  logic  i_load,
  input  addr_t i_load_val,
  input  logic  i_inc,
  output addr_t o_addr
);

  addr_t r_addr;

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= poci_next_addr(r_addr, FIRST_ADDR, MAX_ADDR);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/poci_shifter.sv
// POCI read-data serializer: streams register bytes MSB first from start_addr onward.
// Optional POCI_PARITY_EN appends an odd-parity ninth bit to every byte.
module poci_shifter
  import spi_pkg::*;
#(
  parameter addr_t MAX_ADDR   = POCI_MAX_ADDR,
  parameter addr_t FIRST_ADDR = POCI_FIRST_ADDR
) (
  input logic           sclk,
  input logic           rstn,
  poci_shifter_if.slave bus
);

`ifdef POCI_PARITY_EN
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LAST_CNT = 8;
`else
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned LAST_CNT = 7;
`endif

  poci_state_t       r_state, w_nxt_state;
  logic              r_serial, w_serial;
  logic              r_busy;
  logic              r_byte_done, w_byte_done;
  logic              r_err, w_err;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic              w_load, w_inc, w_in_range;
  addr_t             w_rd_addr;
`ifdef POCI_PARITY_EN
  logic              r_par, w_par;
`endif

  assign w_in_range = (bus.start_addr >= FIRST_ADDR) && (bus.start_addr <= MAX_ADDR);

  // Next state and next register values; stop overrides everything below it.
  always_comb begin
    w_nxt_state = r_state;
    w_serial    = r_serial;
    w_byte_done = 1'b0;
    w_err       = r_err;
    w_cnt       = r_cnt;
    w_shift     = r_shift;
    w_load      = 1'b0;
    w_inc       = 1'b0;
`ifdef POCI_PARITY_EN
    w_par       = r_par;
`endif
    if (bus.stop) begin
      w_nxt_state = IDLE;
      w_serial    = 1'b0;
      w_cnt       = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_serial = 1'b0;
          if (bus.start) begin
            if (w_in_range) begin
              w_load      = 1'b1;
              w_nxt_state = LOAD;
            end else begin
              w_err = 1'b1;
            end
          end
        end
        LOAD, SHIFT: begin
          if (r_state == LOAD || r_cnt == '0) begin
            // Byte boundary: take the mux data directly so bytes run back to back.
            w_serial    = bus.rd_data[7];
            w_shift     = {bus.rd_data[6:0], 1'b0};
            w_cnt       = CNT_W'(1);
            w_nxt_state = SHIFT;
`ifdef POCI_PARITY_EN
            w_par       = ~^bus.rd_data;
`endif
          end else begin
            w_serial = r_shift[7];
            w_shift  = {r_shift[6:0], 1'b0};
            w_cnt    = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LAST_CNT)) begin
              w_byte_done = 1'b1;
              w_inc       = 1'b1;
              w_cnt       = '0;
`ifdef POCI_PARITY_EN
              w_serial    = r_par;
`endif
            end
          end
        end
        default: begin
          w_nxt_state = IDLE;
          w_serial    = 1'b0;
          w_cnt       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_serial    <= 1'b0;
      r_busy      <= 1'b0;
      r_byte_done <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
`ifdef POCI_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_nxt_state;
      r_serial    <= w_serial;
      r_busy      <= (w_nxt_state != IDLE);
      r_byte_done <= w_byte_done;
      r_err       <= w_err;
      r_cnt       <= w_cnt;
      r_shift     <= w_shift;
`ifdef POCI_PARITY_EN
      r_par       <= w_par;
`endif
    end
  end

  poci_addr_ctr #(
    .FIRST_ADDR (FIRST_ADDR),
    .MAX_ADDR   (MAX_ADDR)
  ) u_addr_ctr (
    .sclk       (sclk),
    .rstn       (rstn),
    .i_load     (w_load),
    .i_load_val (bus.start_addr),
    .i_inc      (w_inc),
    .o_addr     (w_rd_addr)
  );

  assign bus.rd_addr    = w_rd_addr;
  assign bus.serial_out = r_serial;
  assign bus.busy       = r_busy;
  assign bus.byte_done  = r_byte_done;
  assign bus.addr_err   = r_err;

endmodule

// File: tb/tb_poci_shifter.sv
// Bench for poci_shifter: stream model predicts every output each cycle; literal vectors pin it.
module tb_poci_shifter;

  localparam int FIRST = 1;
  localparam int MAXA  = 59;
`ifdef POCI_PARITY_EN
  localparam int BPB = 9;
  localparam logic [31:0] EXP_A5_3C = 32'({8'hA5, 1'b1, 8'h3C, 1'b1});
  localparam logic [31:0] EXP_07    = 32'({8'h07, 1'b0});
  localparam logic [31:0] EXP_96    = 32'({8'h96, 1'b1});
`else
  localparam int BPB = 8;
  localparam logic [31:0] EXP_A5_3C = 32'h0000_A53C;
  localparam logic [31:0] EXP_07    = 32'h0000_0007;
  localparam logic [31:0] EXP_96    = 32'h0000_0096;
`endif

  logic sclk;
  logic rstn;
  poci_shifter_if bus();

  logic [7:0] mem [256];
  assign bus.rd_data = mem[bus.rd_addr];

  poci_shifter #(.MAX_ADDR(8'(MAXA)), .FIRST_ADDR(8'(FIRST))) dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: bit n of a transfer is bit (n mod BPB) of the byte at address start+(n/BPB).
  bit         m_valid = 1'b0;
  bit         m_act   = 1'b0;
  int         m_n     = 0;
  int         m_base  = 0;
  logic       e_ser, e_busy, e_bd, e_err;
  logic [7:0] e_addr;

  function automatic logic [7:0] addr_of(input int k);
    return 8'(FIRST + ((m_base - FIRST + k) % (MAXA - FIRST + 1)));
  endfunction

  always @(posedge sclk) begin
    int b, p;
    logic [7:0] d;
    if (!rstn) begin
      m_act = 1'b0; e_ser = 1'b0; e_busy = 1'b0; e_bd = 1'b0; e_err = 1'b0; e_addr = 8'd0;
    end else if (bus.stop) begin
      m_act = 1'b0; e_ser = 1'b0; e_busy = 1'b0; e_bd = 1'b0;
    end else if (!m_act) begin
      e_ser = 1'b0; e_bd = 1'b0;
      if (bus.start) begin
        if (int'(bus.start_addr) >= FIRST && int'(bus.start_addr) <= MAXA) begin
          m_act = 1'b1; m_n = 0; m_base = int'(bus.start_addr);
          e_addr = bus.start_addr; e_busy = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end
    end else begin
      b = m_n / BPB;
      p = m_n % BPB;
      d = mem[addr_of(b)];
      e_ser  = (p < 8) ? d[7-p] : ~^d;
      e_bd   = (p == BPB - 1);
      e_addr = addr_of((m_n + 1) / BPB);
      m_n++;
    end
    m_valid = 1'b1;
  end

  always @(negedge sclk) begin
    if (m_valid) begin
      check("serial_out", 32'(bus.serial_out), 32'(e_ser));
      check("busy",       32'(bus.busy),       32'(e_busy));
      check("byte_done",  32'(bus.byte_done),  32'(e_bd));
      check("addr_err",   32'(bus.addr_err),   32'(e_err));
      check("rd_addr",    32'(bus.rd_addr),    32'(e_addr));
    end
  end

  task automatic step();
    @(negedge sclk);
  endtask

  task automatic start_at(input logic [7:0] a);
    bus.start = 1'b1; bus.start_addr = a;
    step();
    bus.start = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  logic [17:0] cap;
  int          nbd;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[1] = 8'h96; mem[2] = 8'hA5; mem[3] = 8'h3C; mem[5] = 8'h07;

    // Reset held two edges with a valid start pending.
    rstn = 1'b0; bus.start = 1'b1; bus.start_addr = 8'd2; bus.stop = 1'b0;
    step(); step();
    check("rst_serial", 32'(bus.serial_out), 32'd0);
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_rdaddr", 32'(bus.rd_addr),    32'd0);
    check("rst_err",    32'(bus.addr_err),   32'd0);
    rstn = 1'b1; bus.start = 1'b0;
    step();

    // Two gap-free bytes from address 2.
    start_at(8'd2);
    cap = '0; nbd = 0;
    for (int i = 0; i < 2 * BPB; i++) begin
      step();
      cap = {cap[16:0], bus.serial_out};
      nbd += int'(bus.byte_done);
      if (i == BPB - 1) check("addr_after_b0", 32'(bus.rd_addr), 32'd3);
    end
    check("stream_a5_3c", 32'(cap), EXP_A5_3C);
    check("byte_done_cnt", 32'(nbd), 32'd2);
    check("addr_after_b1", 32'(bus.rd_addr), 32'd4);

    // Start while busy is ignored; then stop.
    start_at(8'd10);
    check("busy_ignore_start", 32'(bus.busy), 32'd1);
    stop_pulse();
    check("stop_busy", 32'(bus.busy), 32'd0);

    // Start and stop together: stop wins.
    bus.start = 1'b1; bus.stop = 1'b1; bus.start_addr = 8'd2;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    step();
    check("start_stop_busy", 32'(bus.busy), 32'd0);

    // Wrap at MAX_ADDR.
    start_at(8'd59);
    repeat (BPB) step();
    check("wrap_addr", 32'(bus.rd_addr), 32'd1);
    stop_pulse();

    // Low-weight byte (parity bit 0 when enabled).
    start_at(8'd5);
    cap = '0;
    repeat (BPB) begin
      step();
      cap = {cap[16:0], bus.serial_out};
    end
    check("stream_07", 32'(cap), EXP_07);
    stop_pulse();

    // Out-of-range addresses: below and above the window.
    start_at(8'd0);
    step();
    check("err_lo", 32'(bus.addr_err), 32'd1);
    check("err_lo_busy", 32'(bus.busy), 32'd0);
    stop_pulse();
    check("err_sticky_stop", 32'(bus.addr_err), 32'd1);
    rstn = 1'b0; step(); rstn = 1'b1;
    check("err_cleared", 32'(bus.addr_err), 32'd0);
    start_at(8'd60);
    step();
    check("err_hi", 32'(bus.addr_err), 32'd1);
    check("err_hi_serial", 32'(bus.serial_out), 32'd0);

    // Stop after 4 bits, then a clean transfer from address 1.
    start_at(8'd3);
    repeat (4) step();
    stop_pulse();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_bd",   32'(bus.byte_done), 32'd0);
    start_at(8'd1);
    cap = '0;
    repeat (BPB) begin
      step();
      cap = {cap[16:0], bus.serial_out};
    end
    check("stream_96", 32'(cap), EXP_96);

    // Reset mid-byte: no further bits, no byte_done.
    repeat (3) step();
    rstn = 1'b0; step(); rstn = 1'b1;
    nbd = 0;
    repeat (BPB) begin
      step();
      nbd += int'(bus.byte_done) + int'(bus.serial_out);
    end
    check("mid_rst_quiet", 32'(nbd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/poci_shifter.md
POCI_SHIFTER -- requirements
Module: poci_shifter

Interface
REQ-001 Parameter MAX_ADDR, default 59, highest readable address.
REQ-002 Parameter FIRST_ADDR, default 1, lowest readable address and wrap target.
REQ-003 sclk  input  1  sole clock, all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse: read address byte received, start_addr valid.
REQ-006 stop  input  1  abort/transaction end (sclk stopped or chip deselected).
REQ-007 start_addr  input  8  first register address to read.
REQ-008 rd_addr  output  8  address driven to external register read mux.
REQ-009 rd_data  input  8  combinational mux data for rd_addr.
REQ-010 serial_out  output  1  POCI bit stream, MSB first.
REQ-011 busy  output  1  high in LOAD and SHIFT.
REQ-012 byte_done  output  1  one-cycle pulse when the last bit of a byte is driven.
REQ-013 addr_err  output  1  sticky, set on an out-of-range start_addr.

Function
REQ-014 States: IDLE, LOAD, SHIFT; 3-bit bit_cnt; 8-bit shift_reg.
REQ-015 IDLE with start=1 and FIRST_ADDR<=start_addr<=MAX_ADDR: rd_addr<=start_addr, go to LOAD.
REQ-016 IDLE with start=1 and start_addr out of range: addr_err<=1, stay in IDLE, serial_out stays 0.
REQ-017 LOAD edge: serial_out<=rd_data[7], shift_reg<=rd_data<<1, bit_cnt<=1, go to SHIFT; LOAD lasts exactly one cycle.
REQ-018 SHIFT edge with bit_cnt 1..7: serial_out<=shift_reg[7], shift_reg<<=1, bit_cnt<=bit_cnt+1 (7 wraps to 0).
REQ-019 SHIFT edge with bit_cnt==7: also byte_done<=1 and rd_addr<=next address.
REQ-020 SHIFT edge with bit_cnt==0: reload from rd_data exactly as in LOAD, so consecutive bytes are gap-free at 8 cycles per byte.
REQ-021 Next address: rd_addr+1; if rd_addr==MAX_ADDR the next address is FIRST_ADDR.
REQ-022 stop=1: next edge forces IDLE, busy 0, serial_out 0, byte_done 0, bit_cnt 0; rd_addr and addr_err hold.
REQ-023 Priority: rstn > stop > start; start while busy is ignored; start and stop in the same cycle means stop wins.
REQ-024 addr_err clears only on rstn.
REQ-025 busy is registered and equals (state!=IDLE).

Reset
REQ-026 rstn=0 at an edge: state IDLE; serial_out, busy, byte_done, addr_err 0; rd_addr 0; bit_cnt 0; shift_reg 0.
REQ-027 Reset mid-byte aborts the transfer with no further bits and no byte_done pulse.
REQ-028 All inputs are ignored while rstn=0.

Configuration
REQ-029 With macro POCI_PARITY_EN defined, each byte is followed by a ninth bit carrying odd parity over the 8 data bits.
REQ-030 With parity enabled: bit_cnt is 4 bits wide and counts 0..8, the byte period is 9 cycles, and byte_done pulses when the parity bit is driven.
REQ-031 Without POCI_PARITY_EN: 8-cycle bytes and no parity logic present.

Structure
REQ-032 Shared package spi_pkg holds: the poci_state_t enum (IDLE, LOAD, SHIFT), the addr_t 8-bit typedef, and the POCI_MAX_ADDR=59 and POCI_FIRST_ADDR=1 constants used as parameter defaults.
REQ-033 One sub-module, poci_addr_ctr, holds rd_addr: synchronous load, increment, and wrap.

Verification
REQ-034 rstn low for 2 cycles with start=1 and start_addr=2 -> all outputs 0, no transfer.
REQ-035 start_addr=2, mux returns 0xA5 at address 2 and 0x3C at address 3 -> serial_out 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 contiguous from the LOAD edge, 2 byte_done pulses, rd_addr 2->3->4.
REQ-036 start_addr=59 -> after the first byte, rd_addr=1.
REQ-037 start_addr=0, then a separate transaction with start_addr=60 -> addr_err=1, busy stays 0, serial_out stays 0.
REQ-038 stop asserted after 4 bits of a byte -> next edge busy=0, serial_out=0, no byte_done; a following start_addr=1 transfers correctly.
REQ-039 POCI_PARITY_EN defined, data 0xA5 -> ninth bit 1, byte period 9 cycles; data 0x07 -> ninth bit 0.
